gmux_qen_ctrl: RTL

GMUX_QEN_CTRL -- requirements
Module: gmux_qen_ctrl

---
 rtl/gmux_qen_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/gmux_qen_ctrl.sv
// gmux_qen_ctrl
// Per-quadrant clock-gate enable controller for a global clock mux.
// Each quadrant runs an OFF/ON/DRAIN state machine that decides whether its
// clock-gate enable is high. When a quadrant is released, DRAIN keeps its
// enable high for DRAIN_CYC more cycles so downstream logic can settle.
//
// Optional feature macro: GMUX_QEN_DRAIN_EN
//   defined   : DRAIN state, drain counter and BUSY are present
//   undefined : ON drops straight to OFF, BUSY is tied low
//
// Ports
//   GCLKIN  in   1       global clock, all state on rising edge
//   RST     in   1       synchronous active-high reset
//   SSEL    in   1       0 = static mode (SEN), 1 = dynamic mode (DEN/DYNEN)
//   SEN     in   N_QUAD  per-quadrant static enable
//   DEN     in   N_QUAD  per-quadrant dynamic enable value
//   DYNEN   in   N_QUAD  per-quadrant dynamic update strobe
//   VLP     in   N_QUAD  per-quadrant very-low-power force-off
//   QEN     out  N_QUAD  registered quadrant clock-gate enable
//   BUSY    out  N_QUAD  registered, high while the quadrant drains
//   ALL_OFF out  1       registered, high when every quadrant is OFF
module gmux_qen_ctrl #(
  parameter int N_QUAD    = 4,
  parameter int DRAIN_CYC = 8,
  parameter int CNT_W     = 4
) (
  input  logic              GCLKIN,
  input  logic              RST,
  input  logic              SSEL,
  input  logic [N_QUAD-1:0] SEN,
  input  logic [N_QUAD-1:0] DEN,
  input  logic [N_QUAD-1:0] DYNEN,
  input  logic [N_QUAD-1:0] VLP,
  output logic [N_QUAD-1:0] QEN,
  output logic [N_QUAD-1:0] BUSY,
  output logic              ALL_OFF
);

  // Reject configurations the counter cannot represent.
  if (N_QUAD < 1 || N_QUAD > 16 || CNT_W < 1 ||
      DRAIN_CYC < 1 || DRAIN_CYC > (2**CNT_W) - 1) begin : g_param_check
    $error("gmux_qen_ctrl: illegal parameter combination");
  end

`ifdef GMUX_QEN_DRAIN_EN
  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_ON    = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYC - 1);
`else
  typedef enum logic {
    ST_OFF = 1'b0,
    ST_ON  = 1'b1
  } state_t;
`endif

  state_t            state_q [N_QUAD];
  state_t            state_d [N_QUAD];
  logic [N_QUAD-1:0] den_q;
  logic [N_QUAD-1:0] want;
  logic [N_QUAD-1:0] next_off;

`ifdef GMUX_QEN_DRAIN_EN
  logic [CNT_W-1:0]  cnt_q [N_QUAD];
  logic [CNT_W-1:0]  cnt_d [N_QUAD];
`endif

  // Request per quadrant. In dynamic mode a live strobe bypasses the hold
  // bit so the new DEN value acts on the same edge that captures it.
  always_comb begin
    want = '0;
    for (int i = 0; i < N_QUAD; i++) begin
      if (VLP[i])
        want[i] = 1'b0;
      else if (!SSEL)
        want[i] = SEN[i];
      else
        want[i] = DYNEN[i] ? DEN[i] : den_q[i];
    end
  end

  // Next-state logic. VLP beats everything and skips the drain entirely.
  always_comb begin
    for (int i = 0; i < N_QUAD; i++) begin
      state_d[i] = state_q[i];
`ifdef GMUX_QEN_DRAIN_EN
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_OFF: begin
          if (want[i])
            state_d[i] = ST_ON;
        end
        ST_ON: begin
          if (VLP[i]) begin
            state_d[i] = ST_OFF;
          end else if (!want[i]) begin
            state_d[i] = ST_DRAIN;
            cnt_d[i]   = DRAIN_LOAD;
          end
        end
        ST_DRAIN: begin
          // Counter is only decremented while nonzero, so it cannot wrap.
          if (VLP[i])
            state_d[i] = ST_OFF;
          else if (want[i])
            state_d[i] = ST_ON;
          else if (cnt_q[i] == '0)
            state_d[i] = ST_OFF;
          else
            cnt_d[i] = cnt_q[i] - 1'b1;
        end
        default: state_d[i] = ST_OFF;
      endcase
`else
      if (state_q[i] == ST_OFF) begin
        if (want[i])
          state_d[i] = ST_ON;
      end else begin
        if (!want[i])
          state_d[i] = ST_OFF;
      end
`endif
      next_off[i] = (state_d[i] == ST_OFF);
    end
  end

  // State, hold bits and outputs. Outputs are decoded from the next state
  // so they line up with the state register rather than lagging it.
  always_ff @(posedge GCLKIN) begin
    if (RST) begin
      for (int i = 0; i < N_QUAD; i++) begin
        state_q[i] <= ST_OFF;
`ifdef GMUX_QEN_DRAIN_EN
        cnt_q[i]   <= '0;
`endif
      end
      den_q   <= '0;
      QEN     <= '0;
      ALL_OFF <= 1'b1;
`ifdef GMUX_QEN_DRAIN_EN
      BUSY    <= '0;
`endif
    end else begin
      for (int i = 0; i < N_QUAD; i++) begin
        state_q[i] <= state_d[i];
        QEN[i]     <= (state_d[i] != ST_OFF);
`ifdef GMUX_QEN_DRAIN_EN
        cnt_q[i]   <= cnt_d[i];
        BUSY[i]    <= (state_d[i] == ST_DRAIN);
`endif
      end
      den_q   <= (DYNEN & DEN) | (~DYNEN & den_q);
      ALL_OFF <= &next_off;
    end
  end

`ifndef GMUX_QEN_DRAIN_EN
  assign BUSY = '0;
`endif

endmodule
